// File: rtl/button_led_pkg.sv
// button_led_pkg: shared constants, counter width helper and press-counter operation decode.
package button_led_pkg;
  localparam int SYNC_STAGES = 2;
  typedef enum logic [1:0] {CNT_HOLD, CNT_INC, CNT_DEC} cnt_op_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic cnt_op_t cnt_op(input logic up, input logic dn);
    return (up ^ dn) ? (up ? CNT_INC : CNT_DEC) : CNT_HOLD;
  endfunction
endpackage

// File: rtl/button_led_debounce_edge.sv
// debounce_edge: synchronizes a raw button, debounces it and emits a registered one-cycle rise pulse.
module debounce_edge
  import button_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse
);
  localparam int W = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [W-1:0] cnt;
  logic stable, stable_d, rise, s2;
  assign s2 = sync[SYNC_STAGES-1];
  assign level_out = stable;
  assign rise_pulse = rise;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      cnt <= '0;
      stable <= 1'b0;
      stable_d <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw_in};
      // any sample matching the accepted level restarts the run
      cnt <= (s2 == stable || cnt == LAST) ? '0 : cnt + W'(1);
      stable <= (s2 != stable && cnt == LAST) ? s2 : stable;
      stable_d <= stable;
      rise <= stable & ~stable_d;
    end
  end
endmodule

// File: rtl/button_led_counter.sv
// button_led_counter: debounced up/down buttons stepping a wrap-around LED press counter.
module button_led_counter
  import button_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LED_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_down,
  output logic [LED_W-1:0] io_led,
  output logic up_pulse,
  output logic down_pulse
);
  logic [1:0] unused_levels;
  logic [LED_W-1:0] cnt_q;
  cnt_op_t op;
  debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .rst_n(rst_n), .raw_in(btn_up), .level_out(unused_levels[0]), .rise_pulse(up_pulse)
  );
  debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(clk), .rst_n(rst_n), .raw_in(btn_down), .level_out(unused_levels[1]), .rise_pulse(down_pulse)
  );
  // the step is applied while the pulse is visible and then captured, so io_led moves with the strobe
  assign op = cnt_op(up_pulse, down_pulse);
  always_comb io_led = (op == CNT_INC) ? cnt_q + LED_W'(1) : (op == CNT_DEC) ? cnt_q - LED_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= io_led;
  end
endmodule

// File: tb/tb_button_led_counter.sv
// tb_button_led_counter: directed and random button stimulus checked against a run-length reference model.
module tb_button_led_counter;
  localparam int DC = 8;
  logic clk = 1'b0, rst_n = 1'b1, btn_up = 1'b0, btn_down = 1'b0;
  logic [3:0] io_led;
  logic up_pulse, down_pulse;
  int passed = 0, total = 0;
  bit dq0[2], dq1[2], acc[2], rose[2], mp[2];
  int run[2];
  logic [3:0] m_led;

  always #5 clk = ~clk;

  button_led_counter #(.DEBOUNCE_CYCLES(DC), .LED_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
    .io_led(io_led), .up_pulse(up_pulse), .down_pulse(down_pulse)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      dq0[b] = 0; dq1[b] = 0; acc[b] = 0; rose[b] = 0; mp[b] = 0; run[b] = 0;
    end
    m_led = 4'd0;
  endtask

  // Reference: a level is accepted after DC consecutive synchronized samples that disagree with it;
  // a press strobe follows one cycle after a 0->1 acceptance and moves the count by one.
  task automatic model_step();
    bit raw[2];
    bit seen;
    raw[0] = btn_up;
    raw[1] = btn_down;
    for (int b = 0; b < 2; b++) begin
      seen = dq1[b];
      dq1[b] = dq0[b];
      dq0[b] = raw[b];
      run[b] = (seen != acc[b]) ? run[b] + 1 : 0;
      mp[b] = rose[b];
      rose[b] = 0;
      if (run[b] == DC) begin
        rose[b] = seen;
        acc[b] = seen;
        run[b] = 0;
      end
    end
    if (mp[0] && !mp[1]) m_led = m_led + 4'd1;
    if (mp[1] && !mp[0]) m_led = m_led - 4'd1;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("model_led", io_led, m_led);
      chk("model_up", up_pulse, mp[0]);
      chk("model_down", down_pulse, mp[1]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_led", io_led, 0);
    chk("reset_up", up_pulse, 0);
    chk("reset_down", down_pulse, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic press(input int b);
    if (b == 0) btn_up = 1'b1; else btn_down = 1'b1;
    cyc(14);
    if (b == 0) btn_up = 1'b0; else btn_down = 1'b0;
    cyc(14);
  endtask

  initial begin
    do_reset();
    btn_up = 1'b1;
    cyc(10);
    chk("clean_pre_pulse", up_pulse, 0);
    cyc(1);
    chk("clean_pulse", up_pulse, 1);
    chk("clean_led", io_led, 1);
    cyc(1);
    chk("clean_one_cycle", up_pulse, 0);
    btn_up = 1'b0;
    cyc(20);
    chk("release_led", io_led, 1);

    do_reset();
    repeat (14) begin
      btn_up = ~btn_up;
      cyc(3);
    end
    btn_up = 1'b1;
    cyc(10);
    chk("bounce_pre_pulse", up_pulse, 0);
    cyc(1);
    chk("bounce_pulse", up_pulse, 1);
    chk("bounce_led", io_led, 1);
    btn_up = 1'b0;
    cyc(14);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      press(0);
      chk("wrap_up", io_led, 4'(i + 1));
    end
    press(1);
    chk("wrap_down", io_led, 15);
    for (int i = 0; i < 15; i++) begin
      press(1);
      chk("down_run", io_led, 4'(14 - i));
    end

    repeat (5) press(0);
    chk("pre_simul", io_led, 5);
    btn_up = 1'b1;
    btn_down = 1'b1;
    cyc(11);
    chk("simul_up", up_pulse, 1);
    chk("simul_down", down_pulse, 1);
    chk("simul_led", io_led, 5);
    btn_up = 1'b0;
    btn_down = 1'b0;
    cyc(14);

    btn_down = 1'b1;
    cyc(7);
    btn_down = 1'b0;
    cyc(14);
    chk("thresh_7", io_led, 5);
    btn_down = 1'b1;
    cyc(8);
    btn_down = 1'b0;
    cyc(14);
    chk("thresh_8", io_led, 4);

    repeat (5) press(0);
    chk("pre_reset_led", io_led, 9);
    btn_up = 1'b1;
    cyc(5);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_led", io_led, 0);
    chk("async_up", up_pulse, 0);
    chk("async_down", down_pulse, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(10);
    chk("held_pre_pulse", up_pulse, 0);
    cyc(1);
    chk("held_pulse", up_pulse, 1);
    chk("held_led", io_led, 1);
    btn_up = 1'b0;
    cyc(14);

    repeat (150) begin
      btn_up = 1'($urandom_range(0, 1));
      btn_down = 1'($urandom_range(0, 1));
      cyc($urandom_range(1, 16));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
